// File: rtl/uparc_branch_resolve.sv
// uparc_branch_resolve
//   Registered branch/trap resolution stage between decode and memory,
//   alongside the ALU. It resolves MIPS-I jump/branch conditions, evaluates
//   conditional traps, annuls the delay slot of not-taken branch-likely
//   instructions, flags misaligned targets and keeps saturating
//   taken/not-taken statistics.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_stall           hold everything (except the counter clear)
//   i_nullify         kill the instruction being captured
//   i_jump, i_likely, i_link, i_trap_op   decoded control
//   i_rs_val, i_rt_val                    operands
//   i_target, i_pc_p0                     jump target, return address
//   i_cnt_clr         synchronous statistics clear
//   o_jump_valid/o_jump_addr     taken branch and its target
//   o_link_valid/o_link_addr     link write and return address
//   o_addr_error                 taken with a misaligned target
//   o_cond_trap                  trap condition true
//   o_slot_nullify               delay slot must be annulled upstream
//   o_taken_cnt/o_nt_cnt         saturating statistics
//
// FSM states
//   state   | meaning
//   IDLE    | normal capture
//   KILL    | holds a not-taken likely branch; next capture is the delay
//           | slot and is killed
module uparc_branch_resolve #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int BRLIKELY_EN = 1,
  parameter int TRAP_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_nullify,
  input  logic [3:0]            i_jump,
  input  logic                  i_likely,
  input  logic                  i_link,
  input  logic [2:0]            i_trap_op,
  input  logic [DATA_WIDTH-1:0] i_rs_val,
  input  logic [DATA_WIDTH-1:0] i_rt_val,
  input  logic [ADDR_WIDTH-1:0] i_target,
  input  logic [ADDR_WIDTH-1:0] i_pc_p0,
  input  logic                  i_cnt_clr,
  output logic                  o_jump_valid,
  output logic [ADDR_WIDTH-1:0] o_jump_addr,
  output logic                  o_link_valid,
  output logic [ADDR_WIDTH-1:0] o_link_addr,
  output logic                  o_addr_error,
  output logic                  o_cond_trap,
  output logic                  o_slot_nullify,
  output logic [CNT_WIDTH-1:0]  o_taken_cnt,
  output logic [CNT_WIDTH-1:0]  o_nt_cnt
);

  localparam logic LIKELY_ON = (BRLIKELY_EN != 0);
  localparam logic TRAP_ON   = (TRAP_EN != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_KILL = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  jump_valid_q, jump_valid_d;
  logic [ADDR_WIDTH-1:0] jump_addr_q, jump_addr_d;
  logic                  link_valid_q, link_valid_d;
  logic [ADDR_WIDTH-1:0] link_addr_q, link_addr_d;
  logic                  cond_trap_q, cond_trap_d;
  logic [CNT_WIDTH-1:0]  taken_cnt_q, taken_cnt_d;
  logic [CNT_WIDTH-1:0]  nt_cnt_q, nt_cnt_d;

  logic is_cond;
  logic taken;
  logic trap_hit;
  logic kill;
  logic rs_neg;
  logic rs_zero;
  logic ops_eq;
  logic lt_signed;
  logic lt_unsigned;

  assign rs_neg      = i_rs_val[DATA_WIDTH-1];
  assign rs_zero     = (i_rs_val == '0);
  assign ops_eq      = (i_rs_val == i_rt_val);
  assign lt_signed   = ($signed(i_rs_val) < $signed(i_rt_val));
  assign lt_unsigned = (i_rs_val < i_rt_val);

  always_comb begin
    is_cond = 1'b0;
    taken   = 1'b0;
    case (i_jump)
      4'd1, 4'd2: taken = 1'b1;
      4'd3: begin is_cond = 1'b1; taken = ops_eq; end
      4'd4: begin is_cond = 1'b1; taken = !ops_eq; end
      4'd5: begin is_cond = 1'b1; taken = rs_neg || rs_zero; end
      4'd6: begin is_cond = 1'b1; taken = !rs_neg && !rs_zero; end
      4'd7: begin is_cond = 1'b1; taken = rs_neg; end
      4'd8: begin is_cond = 1'b1; taken = !rs_neg; end
      default: ;
    endcase
  end

  always_comb begin
    trap_hit = 1'b0;
    case (i_trap_op)
      3'd1: trap_hit = ops_eq;
      3'd2: trap_hit = !ops_eq;
      3'd3: trap_hit = lt_signed;
      3'd4: trap_hit = lt_unsigned;
      3'd5: trap_hit = !lt_signed;
      3'd6: trap_hit = !lt_unsigned;
      default: ;
    endcase
  end

  assign kill = i_nullify || (state_q == ST_KILL);

  always_comb begin
    state_d      = state_q;
    jump_valid_d = jump_valid_q;
    jump_addr_d  = jump_addr_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    cond_trap_d  = cond_trap_q;
    taken_cnt_d  = taken_cnt_q;
    nt_cnt_d     = nt_cnt_q;

    if (!i_stall) begin
      if (kill) begin
        // Addresses keep their old value; they are meaningless without valid.
        jump_valid_d = 1'b0;
        link_valid_d = 1'b0;
        cond_trap_d  = 1'b0;
        state_d      = ST_IDLE;
      end else begin
        jump_valid_d = taken;
        jump_addr_d  = i_target;
        link_valid_d = taken && i_link;
        link_addr_d  = i_pc_p0;
        cond_trap_d  = TRAP_ON && trap_hit;
        state_d      = (LIKELY_ON && i_likely && is_cond && !taken) ? ST_KILL : ST_IDLE;
        if (taken && (taken_cnt_q != '1)) begin
          taken_cnt_d = taken_cnt_q + CNT_ONE;
        end
        if (is_cond && !taken && (nt_cnt_q != '1)) begin
          nt_cnt_d = nt_cnt_q + CNT_ONE;
        end
      end
    end

    // Clear wins over increment and also acts while stalled.
    if (i_cnt_clr) begin
      taken_cnt_d = '0;
      nt_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      jump_valid_q <= 1'b0;
      jump_addr_q  <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      cond_trap_q  <= 1'b0;
      taken_cnt_q  <= '0;
      nt_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      jump_valid_q <= jump_valid_d;
      jump_addr_q  <= jump_addr_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      cond_trap_q  <= cond_trap_d;
      taken_cnt_q  <= taken_cnt_d;
      nt_cnt_q     <= nt_cnt_d;
    end
  end

  assign o_jump_valid   = jump_valid_q;
  assign o_jump_addr    = jump_addr_q;
  assign o_link_valid   = link_valid_q;
  assign o_link_addr    = link_addr_q;
  assign o_addr_error   = jump_valid_q && (|jump_addr_q[1:0]);
  assign o_cond_trap    = cond_trap_q;
  assign o_slot_nullify = LIKELY_ON && (state_q == ST_KILL);
  assign o_taken_cnt    = taken_cnt_q;
  assign o_nt_cnt       = nt_cnt_q;

endmodule

// File: tb/tb_uparc_branch_resolve.sv
module tb_uparc_branch_resolve;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_stall = 1'b0, s_null = 1'b0, s_likely = 1'b0, s_link = 1'b0, s_clr = 1'b0;
  logic [3:0]  s_jump = '0;
  logic [2:0]  s_trap = '0;
  logic [31:0] s_rs = '0, s_rt = '0, s_tgt = '0, s_pc = '0;

  logic        o_jv, o_lv, o_ae, o_ct, o_sn;
  logic [31:0] o_ja, o_la;
  logic [15:0] o_tc, o_nc;
  logic        o2_jv, o2_lv, o2_ae, o2_ct, o2_sn;
  logic [31:0] o2_ja, o2_la;
  logic [1:0]  o2_tc, o2_nc;

  always #5 clk = ~clk;

  uparc_branch_resolve dut (
    .clk(clk), .rst(rst), .i_stall(s_stall), .i_nullify(s_null), .i_jump(s_jump),
    .i_likely(s_likely), .i_link(s_link), .i_trap_op(s_trap), .i_rs_val(s_rs),
    .i_rt_val(s_rt), .i_target(s_tgt), .i_pc_p0(s_pc), .i_cnt_clr(s_clr),
    .o_jump_valid(o_jv), .o_jump_addr(o_ja), .o_link_valid(o_lv), .o_link_addr(o_la),
    .o_addr_error(o_ae), .o_cond_trap(o_ct), .o_slot_nullify(o_sn),
    .o_taken_cnt(o_tc), .o_nt_cnt(o_nc)
  );

  // Narrow counters, branch-likely and traps disabled.
  uparc_branch_resolve #(.CNT_WIDTH(2), .BRLIKELY_EN(0), .TRAP_EN(0)) dut2 (
    .clk(clk), .rst(rst), .i_stall(s_stall), .i_nullify(s_null), .i_jump(s_jump),
    .i_likely(s_likely), .i_link(s_link), .i_trap_op(s_trap), .i_rs_val(s_rs),
    .i_rt_val(s_rt), .i_target(s_tgt), .i_pc_p0(s_pc), .i_cnt_clr(s_clr),
    .o_jump_valid(o2_jv), .o_jump_addr(o2_ja), .o_link_valid(o2_lv), .o_link_addr(o2_la),
    .o_addr_error(o2_ae), .o_cond_trap(o2_ct), .o_slot_nullify(o2_sn),
    .o_taken_cnt(o2_tc), .o_nt_cnt(o2_nc)
  );

  typedef struct {
    logic        jv, lv, ae, ct, sn, jcare, lcare;
    logic [31:0] ja, la;
    logic [15:0] tc, nc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic        m_kill[2], m_jv[2], m_lv[2], m_ct[2], m_jcare[2], m_lcare[2];
  logic [31:0] m_ja[2], m_la[2];
  logic [15:0] m_tc[2], m_nc[2];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_kill[k] = 0; m_jv[k] = 0; m_lv[k] = 0; m_ct[k] = 0;
      m_jcare[k] = 1; m_lcare[k] = 1; m_ja[k] = 0; m_la[k] = 0; m_tc[k] = 0; m_nc[k] = 0;
    end
  endtask

  task automatic push_exp(input int k);
    exp_t e;
    e.jv = m_jv[k]; e.ja = m_ja[k]; e.jcare = m_jcare[k];
    e.lv = m_lv[k]; e.la = m_la[k]; e.lcare = m_lcare[k];
    e.ae = m_jv[k] && (m_ja[k][1:0] != 2'b00);
    e.ct = m_ct[k]; e.sn = m_kill[k]; e.tc = m_tc[k]; e.nc = m_nc[k];
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Reference behaviour for one clock edge with the current inputs.
  task automatic model(input int k);
    logic        likely_en, trap_en, cond, tk, trp, kl;
    logic [15:0] mx;
    likely_en = (k == 0);
    trap_en   = (k == 0);
    mx        = (k == 0) ? 16'hFFFF : 16'h0003;
    cond = 0; tk = 0; trp = 0;
    case (s_jump)
      4'd1, 4'd2: tk = 1;
      4'd3: begin cond = 1; tk = (s_rs == s_rt); end
      4'd4: begin cond = 1; tk = (s_rs != s_rt); end
      4'd5: begin cond = 1; tk = ($signed(s_rs) <= 0); end
      4'd6: begin cond = 1; tk = ($signed(s_rs) > 0); end
      4'd7: begin cond = 1; tk = ($signed(s_rs) < 0); end
      4'd8: begin cond = 1; tk = ($signed(s_rs) >= 0); end
      default: ;
    endcase
    case (s_trap)
      3'd1: trp = (s_rs == s_rt);
      3'd2: trp = (s_rs != s_rt);
      3'd3: trp = ($signed(s_rs) < $signed(s_rt));
      3'd4: trp = (s_rs < s_rt);
      3'd5: trp = ($signed(s_rs) >= $signed(s_rt));
      3'd6: trp = (s_rs >= s_rt);
      default: ;
    endcase
    kl = s_null || m_kill[k];
    if (!s_stall) begin
      if (kl) begin
        m_jv[k] = 0; m_lv[k] = 0; m_ct[k] = 0; m_kill[k] = 0;
        m_jcare[k] = 0; m_lcare[k] = 0;
      end else begin
        m_jv[k] = tk; m_ja[k] = s_tgt; m_jcare[k] = 1;
        m_lv[k] = tk && s_link; m_la[k] = s_pc; m_lcare[k] = 1;
        m_ct[k] = trap_en && trp;
        m_kill[k] = likely_en && s_likely && cond && !tk;
        if (tk && m_tc[k] != mx) m_tc[k] = m_tc[k] + 1;
        if (cond && !tk && m_nc[k] != mx) m_nc[k] = m_nc[k] + 1;
      end
    end
    if (s_clr) begin m_tc[k] = 0; m_nc[k] = 0; end
    push_exp(k);
  endtask

  task automatic check_outputs();
    exp_t e;
    n_vec++;
    assert (q0.size() > 0 && q1.size() > 0) else begin
      n_err++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("jump_valid", {31'b0, o_jv}, {31'b0, e.jv});
      if (e.jcare) chk("jump_addr", o_ja, e.ja);
      chk("link_valid", {31'b0, o_lv}, {31'b0, e.lv});
      if (e.lcare) chk("link_addr", o_la, e.la);
      chk("addr_error", {31'b0, o_ae}, {31'b0, e.ae});
      chk("cond_trap", {31'b0, o_ct}, {31'b0, e.ct});
      chk("slot_nullify", {31'b0, o_sn}, {31'b0, e.sn});
      chk("taken_cnt", {16'b0, o_tc}, {16'b0, e.tc});
      chk("nt_cnt", {16'b0, o_nc}, {16'b0, e.nc});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("w2.jump_valid", {31'b0, o2_jv}, {31'b0, e.jv});
      if (e.jcare) chk("w2.jump_addr", o2_ja, e.ja);
      chk("w2.link_valid", {31'b0, o2_lv}, {31'b0, e.lv});
      if (e.lcare) chk("w2.link_addr", o2_la, e.la);
      chk("w2.addr_error", {31'b0, o2_ae}, {31'b0, e.ae});
      chk("w2.cond_trap", {31'b0, o2_ct}, {31'b0, e.ct});
      chk("w2.slot_nullify", {31'b0, o2_sn}, {31'b0, e.sn});
      chk("w2.taken_cnt", {30'b0, o2_tc}, {16'b0, e.tc});
      chk("w2.nt_cnt", {30'b0, o2_nc}, {16'b0, e.nc});
    end
  endtask

  task automatic step(input logic [3:0] jump = 0, input logic likely = 0, input logic link = 0,
                      input logic [2:0] trap = 0, input logic [31:0] rs = 0, input logic [31:0] rt = 0,
                      input logic [31:0] tgt = 0, input logic [31:0] pc = 0,
                      input logic stall = 0, input logic nul = 0, input logic clr = 0);
    @(negedge clk);
    s_jump = jump; s_likely = likely; s_link = link; s_trap = trap;
    s_rs = rs; s_rt = rt; s_tgt = tgt; s_pc = pc;
    s_stall = stall; s_null = nul; s_clr = clr;
    model(0);
    model(1);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    s_jump = 0; s_likely = 0; s_link = 0; s_trap = 0; s_rs = 0; s_rt = 0;
    s_tgt = 0; s_pc = 0; s_stall = 0; s_null = 0; s_clr = 0;
  endtask

  initial begin
    logic [31:0] rs_set [4];
    rs_set[0] = 32'h0000_0000; rs_set[1] = 32'h8000_0000;
    rs_set[2] = 32'h0000_0001; rs_set[3] = 32'hFFFF_FFFF;

    model_reset();
    #2;
    push_exp(0); push_exp(1);
    check_outputs();
    @(posedge clk); #1 rst = 1'b0;

    // Equal-operand BEQ, no link
    step(.jump(3), .rs(32'h1234), .rt(32'h1234), .tgt(32'h100), .pc(32'h48));
    // Not-taken BNE likely, then the killed delay slot J
    step(.jump(4), .likely(1), .rs(7), .rt(7), .tgt(32'h300), .pc(32'h4C));
    step(.jump(1), .tgt(32'h200), .pc(32'h50));
    // Misaligned JR with link
    step(.jump(2), .link(1), .tgt(32'h102), .pc(32'h58));
    // Unsigned vs signed less-than traps
    step(.trap(4), .rs(32'hFFFF_FFFF), .rt(1));
    step(.trap(3), .rs(32'hFFFF_FFFF), .rt(1));
    // Trap and branch together
    step(.jump(3), .trap(1), .rs(5), .rt(5), .tgt(32'h140), .pc(32'h60));
    // Zero-compare branches with link over boundary operands
    for (int j = 5; j <= 8; j++)
      for (int i = 0; i < 4; i++)
        step(.jump(4'(j)), .link(1), .rs(rs_set[i]), .tgt(32'h1000 + 32'(4*i)), .pc(32'h2000 + 32'(j)));
    // All trap ops including the unused encoding
    for (int t = 1; t <= 7; t++) begin
      step(.trap(3'(t)), .rs(32'h8000_0000), .rt(32'h0000_0005));
      step(.trap(3'(t)), .rs(32'h0000_0009), .rt(32'h0000_0009));
    end
    // Unused jump encoding
    step(.jump(12), .tgt(32'h500));
    // Nullified taken jump
    step(.jump(1), .tgt(32'h400), .nul(1));
    // Taken likely behaves as a normal branch
    step(.jump(4), .likely(1), .rs(1), .rt(2), .tgt(32'h600), .pc(32'h64));
    // Nullify while in KILL, then normal capture
    step(.jump(3), .likely(1), .rs(1), .rt(2), .tgt(32'h700));
    step(.jump(1), .tgt(32'h704), .nul(1));
    step(.jump(1), .tgt(32'h708));
    // Stall holds KILL and outputs, then the delay slot is killed
    step(.jump(4), .likely(1), .rs(3), .rt(3), .tgt(32'h800));
    for (int i = 0; i < 3; i++) step(.jump(1), .trap(2), .rs(1), .tgt(32'h900), .stall(1));
    step(.jump(1), .tgt(32'hA00));
    // Stall holds a taken jump across 3 cycles
    step(.jump(2), .link(1), .tgt(32'hB00), .pc(32'hB04));
    for (int i = 0; i < 3; i++) step(.jump(3), .rs(1), .rt(2), .tgt(32'hC00), .stall(1));
    // Clear during stall
    step(.jump(1), .tgt(32'hD00), .stall(1), .clr(1));
    // Saturation of the narrow counters, then clear against an increment
    for (int i = 0; i < 5; i++) step(.jump(1), .tgt(32'hE00 + 32'(4*i)));
    step(.jump(1), .tgt(32'hF00), .clr(1));
    // Build counters 5/3 with KILL pending, then reset mid-cycle
    for (int i = 0; i < 5; i++) step(.jump(1), .tgt(32'h1100));
    for (int i = 0; i < 2; i++) step(.jump(3), .rs(1), .rt(2));
    step(.jump(4), .likely(1), .rs(4), .rt(4), .tgt(32'h1200));
    #3 rst = 1'b1;
    idle_inputs();
    #1;
    model_reset();
    q0.delete(); q1.delete();
    push_exp(0); push_exp(1);
    check_outputs();
    @(posedge clk); #1 rst = 1'b0;
    // First capture after reset is not killed
    step(.jump(1), .tgt(32'h1300), .pc(32'h1304), .link(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
